// File: rtl/host_iface_pkg.sv
`default_nettype none
// =============================================================================
// host_iface_pkg : shared state encoding and helpers for host interface blocks
// Rev 1.0
// =============================================================================
package host_iface_pkg;

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_sel  = 2'd1;
   localparam logic [1:0] c_st_wait = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = c_st_idle,
      ST_SEL  = c_st_sel,
      ST_WAIT = c_st_wait
   } arb_state_t;

   // Index width that never collapses to zero bits for a single source.
   function automatic int clog2_min1(input int value);
      int r;
      r = $clog2(value);
      return (r < 1) ? 1 : r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/out_arb_rr_pick.sv
`default_nettype none
// =============================================================================
// rr_pick : round-robin pick of the first masked requester after last_i
// Rev 1.0
// =============================================================================
module rr_pick
   import host_iface_pkg::*;
#(
   parameter  int N_SRCS = 2,
   localparam int SRC_W  = clog2_min1(N_SRCS)
)(
   input  logic [N_SRCS-1:0] req_i,
   input  logic [N_SRCS-1:0] mask_i,
   input  logic [SRC_W-1:0]  last_i,
   output logic [SRC_W-1:0]  idx_o,
   output logic              valid_o
);

   logic [N_SRCS-1:0] w_req;
   logic [SRC_W-1:0]  w_cand;

   assign w_req = req_i & mask_i;

   // Scan farthest offset first so the nearest requester after last_i wins.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      w_cand  = '0;
      for (int off = N_SRCS; off >= 1; off--) begin
         w_cand = SRC_W'((int'(last_i) + off) % N_SRCS);
         if (w_req[w_cand]) begin
            idx_o   = w_cand;
            valid_o = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/out_arb.sv
`default_nettype none
// =============================================================================
// out_arb : round-robin output arbiter with priority class and bounded bursts
// Rev 1.0
// =============================================================================
module out_arb
   import host_iface_pkg::*;
#(
   parameter  int                N_SRCS    = 2,
   parameter  int                DATA_W    = 8,
   parameter  int                MAX_BURST = 16,
   parameter  logic [N_SRCS-1:0] PRIO_MASK = N_SRCS'(1),
   localparam int                SRC_W     = clog2_min1(N_SRCS)
)(
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [N_SRCS*DATA_W-1:0]   omux_data_i,
   input  logic [N_SRCS-1:0]          omux_req_i,
   output logic [N_SRCS-1:0]          omux_sel_o,
   output logic [DATA_W-1:0]          out_o,
   output logic [SRC_W-1:0]           out_src_o,
   output logic                       out_req_o,
   input  logic                       out_ack_i
);

   localparam int               c_cnt_w         = clog2_min1(MAX_BURST + 1);
   localparam logic [c_cnt_w-1:0] c_burst_max   = c_cnt_w'(MAX_BURST);
   localparam bit               c_burst_limited = (MAX_BURST != 0);

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic [SRC_W-1:0]    r_grant;
   logic [SRC_W-1:0]    r_last;
   logic [c_cnt_w-1:0]  r_burst_cnt;
   logic [DATA_W-1:0]   r_out;
   logic [SRC_W-1:0]    r_out_src;
   logic [N_SRCS-1:0]   w_prio_req;
   logic [N_SRCS-1:0]   w_mask;
   logic [SRC_W-1:0]    w_pick_idx;
   logic                w_pick_valid;
   logic                w_req_granted;
   logic                w_burst_done;
   logic [DATA_W-1:0]   w_src_data [N_SRCS];

   generate
      for (genvar k = 0; k < N_SRCS; k++) begin : g_unpack
         assign w_src_data[k] = omux_data_i[k*DATA_W +: DATA_W];
      end
   endgenerate

   // Restrict the candidates to the priority class whenever any of it is requesting.
   assign w_prio_req = omux_req_i & PRIO_MASK;
   assign w_mask     = (|w_prio_req) ? PRIO_MASK : '1;

   rr_pick #(
      .N_SRCS (N_SRCS)
   ) u_rr_pick (
      .req_i   (omux_req_i),
      .mask_i  (w_mask),
      .last_i  (r_last),
      .idx_o   (w_pick_idx),
      .valid_o (w_pick_valid)
   );

   assign w_req_granted = omux_req_i[r_grant];
   assign w_burst_done  = c_burst_limited && (r_burst_cnt == c_burst_max);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (|omux_req_i) w_state_nxt = ST_SEL;
         ST_SEL:  w_state_nxt = w_req_granted ? ST_WAIT : ST_IDLE;
         ST_WAIT: if (out_ack_i) w_state_nxt = w_burst_done ? ST_IDLE : ST_SEL;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_grant     <= '0;
         r_last      <= SRC_W'(N_SRCS - 1);
         r_burst_cnt <= '0;
         r_out       <= '0;
         r_out_src   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_burst_cnt <= '0;
               if (w_pick_valid) r_grant <= w_pick_idx;
            end
            ST_SEL: begin
               if (w_req_granted) begin
                  r_out       <= w_src_data[r_grant];
                  r_out_src   <= r_grant;
                  r_burst_cnt <= r_burst_cnt + c_cnt_w'(1);
               end else begin
                  r_last <= r_grant;
               end
            end
            ST_WAIT: if (out_ack_i && w_burst_done) r_last <= r_grant;
            default: ;
         endcase
      end
   end

   assign omux_sel_o = (r_state == ST_SEL) ? (N_SRCS'(1) << r_grant) : '0;
   assign out_req_o  = (r_state == ST_WAIT);
   assign out_o      = r_out;
   assign out_src_o  = r_out_src;

endmodule
`default_nettype wire

// File: tb/tb_out_arb.sv
`default_nettype none
// tb_out_arb : four out_arb configurations checked every cycle against a
// behavioural model of the arbitration rules, plus hand-computed sequences.
module tb_out_arb;

   localparam int NU = 4;
   localparam int P_N  [NU] = '{2, 3, 3, 1};
   localparam int P_MB [NU] = '{16, 2, 4, 0};
   localparam int P_PM [NU] = '{0, 0, 1, 0};
   localparam int PH_IDLE = 0, PH_OFFER = 1, PH_HOLD = 2;

   typedef struct {
      int src;
      int dat;
      int cyc;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [2:0]  req_v  [NU];
   logic [23:0] data_v [NU];
   logic        ack_v  [NU];
   bit          auto_ack [NU];
   int          rem [NU][3];
   logic [7:0]  nxt [NU][3];

   logic [2:0] d_sel [NU];
   logic       d_req [NU];
   logic [7:0] d_out [NU];
   logic [1:0] d_src [NU];

   int   m_ph [NU], m_gr [NU], m_last [NU], m_cnt [NU], m_src [NU];
   logic [7:0] m_out [NU];

   ent_t logq [NU][$];
   bit   prev_req [NU];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   logic [1:0] sel0; logic       src0; logic [7:0] out0; logic oreq0;
   logic [2:0] sel1; logic [1:0] src1; logic [7:0] out1; logic oreq1;
   logic [2:0] sel2; logic [1:0] src2; logic [7:0] out2; logic oreq2;
   logic [0:0] sel3; logic       src3; logic [7:0] out3; logic oreq3;

   out_arb #(.N_SRCS(2), .DATA_W(8), .MAX_BURST(16), .PRIO_MASK(2'b00)) u0 (
      .clk_i(clk), .reset_i(rst), .omux_data_i(data_v[0][15:0]), .omux_req_i(req_v[0][1:0]),
      .omux_sel_o(sel0), .out_o(out0), .out_src_o(src0), .out_req_o(oreq0), .out_ack_i(ack_v[0]));
   out_arb #(.N_SRCS(3), .DATA_W(8), .MAX_BURST(2), .PRIO_MASK(3'b000)) u1 (
      .clk_i(clk), .reset_i(rst), .omux_data_i(data_v[1]), .omux_req_i(req_v[1]),
      .omux_sel_o(sel1), .out_o(out1), .out_src_o(src1), .out_req_o(oreq1), .out_ack_i(ack_v[1]));
   out_arb #(.N_SRCS(3), .DATA_W(8), .MAX_BURST(4), .PRIO_MASK(3'b001)) u2 (
      .clk_i(clk), .reset_i(rst), .omux_data_i(data_v[2]), .omux_req_i(req_v[2]),
      .omux_sel_o(sel2), .out_o(out2), .out_src_o(src2), .out_req_o(oreq2), .out_ack_i(ack_v[2]));
   out_arb #(.N_SRCS(1), .DATA_W(8), .MAX_BURST(0), .PRIO_MASK(1'b0)) u3 (
      .clk_i(clk), .reset_i(rst), .omux_data_i(data_v[3][7:0]), .omux_req_i(req_v[3][0:0]),
      .omux_sel_o(sel3), .out_o(out3), .out_src_o(src3), .out_req_o(oreq3), .out_ack_i(ack_v[3]));

   always_comb begin
      d_sel[0] = {1'b0, sel0};  d_src[0] = {1'b0, src0}; d_out[0] = out0; d_req[0] = oreq0;
      d_sel[1] = sel1;          d_src[1] = src1;         d_out[1] = out1; d_req[1] = oreq1;
      d_sel[2] = sel2;          d_src[2] = src2;         d_out[2] = out2; d_req[2] = oreq2;
      d_sel[3] = {2'b00, sel3}; d_src[3] = {1'b0, src3}; d_out[3] = out3; d_req[3] = oreq3;
   end

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   function automatic int pick(input int u);
      int n, cls;
      n   = P_N[u];
      cls = int'(req_v[u]) & ((1 << n) - 1);
      if ((cls & P_PM[u]) != 0) cls = cls & P_PM[u];
      for (int off = 1; off <= n; off++)
         if (((cls >> ((m_last[u] + off) % n)) & 1) != 0) return (m_last[u] + off) % n;
      return -1;
   endfunction

   task automatic model_reset();
      for (int u = 0; u < NU; u++) begin
         m_ph[u] = PH_IDLE; m_gr[u] = 0; m_last[u] = P_N[u] - 1;
         m_cnt[u] = 0; m_out[u] = 8'h00; m_src[u] = 0;
      end
   endtask

   task automatic model_step(input int u);
      case (m_ph[u])
         PH_IDLE: begin
            m_cnt[u] = 0;
            if ((int'(req_v[u]) & ((1 << P_N[u]) - 1)) != 0) begin
               m_gr[u] = pick(u);
               m_ph[u] = PH_OFFER;
            end
         end
         PH_OFFER: begin
            if (req_v[u][m_gr[u]]) begin
               m_out[u] = data_v[u][m_gr[u]*8 +: 8];
               m_src[u] = m_gr[u];
               m_cnt[u]++;
               m_ph[u]  = PH_HOLD;
            end else begin
               m_last[u] = m_gr[u];
               m_ph[u]   = PH_IDLE;
            end
         end
         default: begin
            if (ack_v[u]) begin
               if (P_MB[u] != 0 && m_cnt[u] == P_MB[u]) begin
                  m_last[u] = m_gr[u];
                  m_ph[u]   = PH_IDLE;
               end else begin
                  m_ph[u] = PH_OFFER;
               end
            end
         end
      endcase
   endtask

   initial forever begin
      @(posedge clk);
      if (!rst) for (int u = 0; u < NU; u++) model_step(u);
   end

   // Compare every cycle, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         for (int u = 0; u < NU; u++) begin
            check($sformatf("u%0d sel", u), 32'(d_sel[u]),
                  (m_ph[u] == PH_OFFER) ? (32'd1 << m_gr[u]) : 32'd0);
            check($sformatf("u%0d out_req", u), 32'(d_req[u]), 32'(m_ph[u] == PH_HOLD));
            check($sformatf("u%0d out", u), 32'(d_out[u]), 32'(m_out[u]));
            check($sformatf("u%0d out_src", u), 32'(d_src[u]), 32'(m_src[u]));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // Sources present the next word while selected and hold their request until
   // the word after the last one would be due.
   initial forever begin
      @(negedge clk);
      for (int u = 0; u < NU; u++)
         for (int s = 0; s < P_N[u]; s++) begin
            if (d_sel[u][s] && rem[u][s] > 0) begin
               data_v[u][s*8 +: 8] = nxt[u][s];
               nxt[u][s] = nxt[u][s] + 8'd1;
               rem[u][s]--;
            end else begin
               req_v[u][s] = (rem[u][s] > 0);
            end
         end
   end

   initial forever begin
      @(negedge clk);
      for (int u = 0; u < NU; u++) if (auto_ack[u]) ack_v[u] = d_req[u];
   end

   initial forever begin
      @(negedge clk);
      for (int u = 0; u < NU; u++) begin
         if (d_req[u] && !prev_req[u]) logq[u].push_back('{int'(d_src[u]), int'(d_out[u]), cyc});
         prev_req[u] = d_req[u];
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_words(input int u, input int n, input int budget);
      int k = 0;
      while (logq[u].size() < n && k < budget) begin tick(); k++; end
      check($sformatf("u%0d %0d words arrive", u, n), 32'(logq[u].size() >= n), 32'd1);
   endtask

   task automatic chk_word(input int u, input int i, input int esrc, input int edat, input int egap);
      check($sformatf("u%0d word%0d present", u, i), 32'(logq[u].size() > i), 32'd1);
      if (logq[u].size() > i) begin
         check($sformatf("u%0d word%0d src", u, i), 32'(logq[u][i].src), 32'(esrc));
         check($sformatf("u%0d word%0d data", u, i), 32'(logq[u][i].dat), 32'(edat));
         if (i > 0 && egap > 0)
            check($sformatf("u%0d word%0d gap", u, i),
                  32'(logq[u][i].cyc - logq[u][i-1].cyc), 32'(egap));
      end
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int exp_src [$];
      int exp_dat [$];
      for (int u = 0; u < NU; u++) begin
         req_v[u] = '0; data_v[u] = '0; ack_v[u] = 1'b0; auto_ack[u] = 1'b1; prev_req[u] = 1'b0;
         for (int s = 0; s < 3; s++) begin rem[u][s] = 0; nxt[u][s] = 8'h00; end
      end
      model_reset();
      repeat (3) @(negedge clk);
      for (int u = 0; u < NU; u++) begin
         check($sformatf("u%0d reset sel", u), 32'(d_sel[u]), 32'd0);
         check($sformatf("u%0d reset out_req", u), 32'(d_req[u]), 32'd0);
         check($sformatf("u%0d reset out", u), 32'(d_out[u]), 32'd0);
      end
      #1 rst = 1'b0;

      // Single source, three words, 2 cycles per word.
      nxt[0][1] = 8'hA1; rem[0][1] = 3;
      wait_words(0, 3, 60);
      chk_word(0, 0, 1, 8'hA1, 0);
      chk_word(0, 1, 1, 8'hA2, 2);
      chk_word(0, 2, 1, 8'hA3, 2);
      repeat (4) tick();

      // Ack withheld: output word held while the data bus churns.
      logq[0].delete();
      auto_ack[0] = 1'b0; ack_v[0] = 1'b0;
      nxt[0][0] = 8'h55; rem[0][0] = 1;
      wait_words(0, 1, 20);
      for (int k = 0; k < 10; k++) begin
         data_v[0] = 24'($urandom);
         tick();
         check("hold out", 32'(d_out[0]), 32'h55);
         check("hold out_req", 32'(d_req[0]), 32'd1);
         check("hold sel", 32'(d_sel[0]), 32'd0);
      end
      ack_v[0] = 1'b1; tick(); ack_v[0] = 1'b0; auto_ack[0] = 1'b1;
      repeat (4) tick();

      // Round robin across three sources with two-word bursts.
      for (int s = 0; s < 3; s++) begin nxt[1][s] = 8'h10 + 8'(16 * s); rem[1][s] = 4; end
      wait_words(1, 12, 200);
      exp_src = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2};
      exp_dat = '{'h10, 'h11, 'h20, 'h21, 'h30, 'h31, 'h12, 'h13, 'h22, 'h23, 'h32, 'h33};
      for (int i = 0; i < 12; i++) chk_word(1, i, exp_src[i], exp_dat[i], (i % 2 == 1) ? 2 : 3);
      repeat (4) tick();

      // Priority source arrives mid-burst and waits for the next arbitration.
      nxt[2][1] = 8'h40; rem[2][1] = 8;
      nxt[2][2] = 8'h50; rem[2][2] = 4;
      wait_words(2, 1, 20);
      nxt[2][0] = 8'h30; rem[2][0] = 2;
      wait_words(2, 14, 200);
      exp_src = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
      exp_dat = '{'h40, 'h41, 'h42, 'h43, 'h30, 'h31, 'h44, 'h45, 'h46, 'h47, 'h50, 'h51, 'h52, 'h53};
      for (int i = 0; i < 14; i++)
         chk_word(2, i, exp_src[i], exp_dat[i], (i == 4) ? 3 : (i == 6) ? 4 : 0);
      repeat (4) tick();

      // Unlimited burst: 40 back-to-back words, never re-arbitrated.
      nxt[3][0] = 8'hC0; rem[3][0] = 40;
      wait_words(3, 40, 200);
      for (int i = 0; i < 40; i++) chk_word(3, i, 0, 'hC0 + i, 2);
      repeat (4) tick();

      // Asynchronous reset mid-WAIT, then lowest-index requester wins.
      logq[0].delete();
      nxt[0][0] = 8'h60; rem[0][0] = 3;
      nxt[0][1] = 8'h70; rem[0][1] = 3;
      begin
         int k = 0;
         while (!d_req[0] && k < 20) begin tick(); k++; end
         check("pre-reset out_req", 32'(d_req[0]), 32'd1);
      end
      rst = 1'b1;
      model_reset();
      #1;
      check("async reset out_req", 32'(d_req[0]), 32'd0);
      check("async reset sel", 32'(d_sel[0]), 32'd0);
      check("async reset out", 32'(d_out[0]), 32'd0);
      #1 rst = 1'b0;
      logq[0].delete();
      wait_words(0, 5, 60);
      chk_word(0, 0, 0, 8'h60, 0);
      chk_word(0, 1, 0, 8'h61, 2);
      chk_word(0, 2, 0, 8'h62, 2);
      chk_word(0, 3, 1, 8'h71, 4);
      chk_word(0, 4, 1, 8'h72, 2);
      repeat (5) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
